// File: rtl/morse_tx.sv
// Morse transmitter: accepts a letter index, latches its dot/dash pattern and keys
// it serially on key_out with unit timing (dot=1U, dash=3U, gap=1U, letter gap=3U).
module morse_tx #(
   parameter int UNIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] letter_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       key_out,
   output logic [3:0] code_out,
   output logic [2:0] len_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       err_out
);

   localparam int CW = $clog2(3*UNIT_CYCLES+1);
   localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES);
   localparam logic [CW-1:0] DASH_LD = CW'(3*UNIT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [3:0]      code_q, code_d;
   logic [2:0]      len_q, len_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic [3:0]      tbl_code;
   logic [2:0]      tbl_len;
   logic [1:0]      nxt_ptr;
   logic            more_syms;
   logic            nxt_dash;

   // ITU pattern table, symbol 0 in bit 3, 1=dash.
   always_comb begin
      {tbl_code, tbl_len} = {4'b0000, 3'd0};
      case (letter_in)
         5'd0:  {tbl_code, tbl_len} = {4'b0100, 3'd2};
         5'd1:  {tbl_code, tbl_len} = {4'b1000, 3'd4};
         5'd2:  {tbl_code, tbl_len} = {4'b1010, 3'd4};
         5'd3:  {tbl_code, tbl_len} = {4'b1000, 3'd3};
         5'd4:  {tbl_code, tbl_len} = {4'b0000, 3'd1};
         5'd5:  {tbl_code, tbl_len} = {4'b0010, 3'd4};
         5'd6:  {tbl_code, tbl_len} = {4'b1100, 3'd3};
         5'd7:  {tbl_code, tbl_len} = {4'b0000, 3'd4};
         5'd8:  {tbl_code, tbl_len} = {4'b0000, 3'd2};
         5'd9:  {tbl_code, tbl_len} = {4'b0111, 3'd4};
         5'd10: {tbl_code, tbl_len} = {4'b1010, 3'd3};
         5'd11: {tbl_code, tbl_len} = {4'b0100, 3'd4};
         5'd12: {tbl_code, tbl_len} = {4'b1100, 3'd2};
         5'd13: {tbl_code, tbl_len} = {4'b1000, 3'd2};
         5'd14: {tbl_code, tbl_len} = {4'b1110, 3'd3};
         5'd15: {tbl_code, tbl_len} = {4'b0110, 3'd4};
         5'd16: {tbl_code, tbl_len} = {4'b1101, 3'd4};
         5'd17: {tbl_code, tbl_len} = {4'b0100, 3'd3};
         5'd18: {tbl_code, tbl_len} = {4'b0000, 3'd3};
         5'd19: {tbl_code, tbl_len} = {4'b1000, 3'd1};
         5'd20: {tbl_code, tbl_len} = {4'b0010, 3'd3};
         5'd21: {tbl_code, tbl_len} = {4'b0001, 3'd4};
         5'd22: {tbl_code, tbl_len} = {4'b0110, 3'd3};
         5'd23: {tbl_code, tbl_len} = {4'b1001, 3'd4};
         5'd24: {tbl_code, tbl_len} = {4'b1011, 3'd4};
         5'd25: {tbl_code, tbl_len} = {4'b1100, 3'd4};
         default: {tbl_code, tbl_len} = {4'b0000, 3'd0};
      endcase
   end

   assign nxt_ptr   = ptr_q + 2'd1;
   assign nxt_dash  = code_q[2'd3 - nxt_ptr];
   assign more_syms = ({1'b0, ptr_q} + 3'd1) < len_q;

   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      code_d  = code_q;
      len_d   = len_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               if (letter_in <= 5'd25) begin
                  code_d  = tbl_code;
                  len_d   = tbl_len;
                  ptr_d   = 2'd0;
                  cnt_d   = tbl_code[3] ? DASH_LD : DOT_LD;
                  state_d = MARK;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         MARK: begin
            if (cnt_q == CNT_ONE) begin
               state_d = more_syms ? SPACE : LGAP;
               cnt_d   = more_syms ? DOT_LD : DASH_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         SPACE: begin
            if (cnt_q == CNT_ONE) begin
               ptr_d   = nxt_ptr;
               cnt_d   = nxt_dash ? DASH_LD : DOT_LD;
               state_d = MARK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         LGAP: begin
            if (cnt_q == CNT_ONE) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state lives in flops updated with <= only; key_out is decoded from state so reset drops it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= 2'd0;
         code_q  <= 4'd0;
         len_q   <= 3'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         code_q  <= code_d;
         len_q   <= len_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign key_out   = (state_q == MARK);
   assign ready_out = (state_q == IDLE);
   assign busy_out  = ~ready_out;
   assign code_out  = code_q;
   assign len_out   = len_q;
   assign done_out  = done_q;
   assign err_out   = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: stimulus queues expected letters, per-instance
// monitors record key_out while busy and compare on each done/err pulse.
module tb_morse_tx;

   typedef struct {
      int           inst;
      bit           err;
      logic [3:0]   code;
      logic [2:0]   len;
      int           busy;
      logic [127:0] key;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] letter [2];
   logic       vin    [2];
   logic       key_o  [2];
   logic       rdy    [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       err_o  [2];
   logic [3:0] code_o [2];
   logic [2:0] len_o  [2];

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_pass = 0;

   logic [6:0] tbl [26] = '{
      {4'b0100,3'd2}, {4'b1000,3'd4}, {4'b1010,3'd4}, {4'b1000,3'd3}, {4'b0000,3'd1},
      {4'b0010,3'd4}, {4'b1100,3'd3}, {4'b0000,3'd4}, {4'b0000,3'd2}, {4'b0111,3'd4},
      {4'b1010,3'd3}, {4'b0100,3'd4}, {4'b1100,3'd2}, {4'b1000,3'd2}, {4'b1110,3'd3},
      {4'b0110,3'd4}, {4'b1101,3'd4}, {4'b0100,3'd3}, {4'b0000,3'd3}, {4'b1000,3'd1},
      {4'b0010,3'd3}, {4'b0001,3'd4}, {4'b0110,3'd3}, {4'b1001,3'd4}, {4'b1011,3'd4},
      {4'b1100,3'd4}};

   always #5 clk = ~clk;

   morse_tx #(.UNIT_CYCLES(2)) u_dut_u2 (
      .clk(clk), .rst_n(rst_n), .letter_in(letter[0]), .valid_in(vin[0]),
      .ready_out(rdy[0]), .key_out(key_o[0]), .code_out(code_o[0]), .len_out(len_o[0]),
      .busy_out(busy_o[0]), .done_out(done_o[0]), .err_out(err_o[0]));

   morse_tx #(.UNIT_CYCLES(1)) u_dut_u1 (
      .clk(clk), .rst_n(rst_n), .letter_in(letter[1]), .valid_in(vin[1]),
      .ready_out(rdy[1]), .key_out(key_o[1]), .code_out(code_o[1]), .len_out(len_o[1]),
      .busy_out(busy_o[1]), .done_out(done_o[1]), .err_out(err_o[1]));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected keying from alternating run lengths, starting with a mark; 0 ends the list.
   function automatic exp_t mk_runs(input int inst, input logic [3:0] code,
                                    input logic [2:0] len, input int r[10]);
      exp_t e;
      bit   lvl = 1'b1;
      e.inst = inst; e.err = 1'b0; e.code = code; e.len = len;
      e.key = '0; e.busy = 0;
      for (int i = 0; i < 10; i++) begin
         if (r[i] == 0) break;
         for (int j = 0; j < r[i]; j++) begin
            e.key[e.busy] = lvl;
            e.busy++;
         end
         lvl = ~lvl;
      end
      return e;
   endfunction

   function automatic exp_t mk_letter(input int inst, input logic [3:0] code,
                                      input logic [2:0] len, input int u);
      int r[10];
      int k = 0;
      for (int i = 0; i < 10; i++) r[i] = 0;
      for (int i = 0; i < int'(len); i++) begin
         r[k] = (code[3-i] ? 3 : 1) * u;
         r[k+1] = (i == int'(len) - 1) ? 3 * u : u;
         k += 2;
      end
      return mk_letter_runs(inst, code, len, r);
   endfunction

   function automatic exp_t mk_letter_runs(input int inst, input logic [3:0] code,
                                           input logic [2:0] len, input int r[10]);
      return mk_runs(inst, code, len, r);
   endfunction

   task automatic wait_ready(input int inst);
      int k = 0;
      while (!rdy[inst] && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (!rdy[inst]) check("ready_timeout", 0, 1);
   endtask

   task automatic send(input int inst, input logic [4:0] l, input exp_t e);
      exp_q.push_back(e);
      wait_ready(inst);
      letter[inst] = l;
      vin[inst] = 1'b1;
      @(negedge clk);
      vin[inst] = 1'b0;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      logic [127:0] cap = '0;
      int           cnt = 0;
      always @(negedge clk) begin
         exp_t e;
         if (!rst_n) begin
            cap = '0;
            cnt = 0;
         end else begin
            if (busy_o[g]) begin
               if (cnt < 128) cap[cnt] = key_o[g];
               cnt++;
            end
            if (done_o[g] || err_o[g]) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("unexpected_output_dut%0d", g), 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("instance", g, e.inst);
                  check("is_err", err_o[g], e.err);
                  check("code_out", code_o[g], e.code);
                  check("len_out", len_o[g], e.len);
                  if (err_o[g]) begin
                     check("err_key_out", key_o[g], 0);
                     check("err_ready_out", rdy[g], 1);
                  end else begin
                     check("busy_cycles", cnt, e.busy);
                     check("key_pattern", cap, e.key);
                  end
               end
               cap = '0;
               cnt = 0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      letter[0] = 5'd0; letter[1] = 5'd0;
      vin[0] = 1'b0; vin[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", rdy[0], 1);
      check("rst_key", key_o[0], 0);
      check("rst_code", code_o[0], 0);
      check("rst_len", len_o[0], 0);
      check("rst_done_err", {done_o[0], err_o[0], busy_o[0]}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // C, then E, then an invalid index (code/len must stay at E's)
      send(0, 5'd2, mk_runs(0, 4'b1010, 3'd4, '{6, 2, 2, 2, 6, 2, 2, 6, 0, 0}));
      send(0, 5'd4, mk_runs(0, 4'b0000, 3'd1, '{2, 6, 0, 0, 0, 0, 0, 0, 0, 0}));
      e.inst = 0; e.err = 1'b1; e.code = 4'b0000; e.len = 3'd1; e.busy = 0; e.key = '0;
      send(0, 5'd27, e);
      repeat (3) @(negedge clk);

      // T then M with valid held; letter_in wanders while busy
      exp_q.push_back(mk_runs(0, 4'b1000, 3'd1, '{6, 6, 0, 0, 0, 0, 0, 0, 0, 0}));
      wait_ready(0);
      letter[0] = 5'd19;
      vin[0] = 1'b1;
      @(negedge clk);
      letter[0] = 5'd0;
      repeat (5) @(negedge clk);
      letter[0] = 5'd30;
      exp_q.push_back(mk_runs(0, 4'b1100, 3'd2, '{6, 2, 6, 6, 0, 0, 0, 0, 0, 0}));
      wait_ready(0);
      check("t_m_done_cycle", done_o[0], 1);
      letter[0] = 5'd12;
      @(negedge clk);
      vin[0] = 1'b0;

      // reset in the middle of B's first dash
      wait_ready(0);
      letter[0] = 5'd1;
      vin[0] = 1'b1;
      @(negedge clk);
      vin[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_key", key_o[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_key", key_o[0], 0);
      check("midrst_ready", rdy[0], 1);
      check("midrst_code", code_o[0], 0);
      check("midrst_len", len_o[0], 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // UNIT_CYCLES=1: every letter
      for (int i = 0; i < 26; i++)
         send(1, 5'(i), mk_letter(1, tbl[i][6:3], tbl[i][2:0], 1));

      begin
         int k = 0;
         while (exp_q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
         end
         if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      end
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
